// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and the round-robin search used by bus_arbiter4.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Returns {found, index} of the first set request scanning ptr, ptr+1, ... mod 4.
    function automatic logic [2:0] pick_rr(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter4_mux4.sv
`default_nettype none
// ============================================================================
//  Module      : Mux4
//  Description : Four-input payload multiplexer steering the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module Mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter4
//  Description : Round-robin arbiter sharing one bus port among four requesters,
//                with release on accept, withdrawal or hold timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter4
    import arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             bus_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             timeout_err
);

    localparam logic [7:0] c_hold_last = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    arb_state_t  r_state;
    logic [1:0]  r_ptr;
    logic [7:0]  r_hold_cnt;
    logic [3:0]  r_gnt;
    logic [1:0]  r_sel;
    logic        r_bus_valid;
    logic        r_timeout_err;

    logic        w_done;
    logic        w_timeout;
    logic [3:0]  w_search_req;
    logic [1:0]  w_search_ptr;
    logic [2:0]  w_pick;

    // While busy the next winner is searched from w+1, which is the updated ptr.
    always_comb begin
        w_done       = bus_ready | ~req[r_sel];
        w_timeout    = (MAX_HOLD != 0) && !w_done && (r_hold_cnt == c_hold_last);
        w_search_req = w_timeout ? (req & ~r_gnt) : req;
        w_search_ptr = (r_state == BUSY) ? (r_sel + 2'd1) : r_ptr;
        w_pick       = pick_rr(w_search_req, w_search_ptr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= 2'd0;
            r_hold_cnt    <= 8'd0;
            r_gnt         <= 4'b0000;
            r_sel         <= 2'd0;
            r_bus_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick[2]) begin
                        r_state     <= BUSY;
                        r_gnt       <= 4'b0001 << w_pick[1:0];
                        r_sel       <= w_pick[1:0];
                        r_bus_valid <= 1'b1;
                        r_hold_cnt  <= 8'd0;
                    end
                end
                BUSY: begin
                    if (w_done || w_timeout) begin
                        r_ptr         <= r_sel + 2'd1;
                        r_timeout_err <= w_timeout;
                        r_hold_cnt    <= 8'd0;
                        if (w_pick[2]) begin
                            r_gnt <= 4'b0001 << w_pick[1:0];
                            r_sel <= w_pick[1:0];
                        end else begin
                            r_state     <= IDLE;
                            r_gnt       <= 4'b0000;
                            r_sel       <= 2'd0;
                            r_bus_valid <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign sel         = r_sel;
    assign bus_valid   = r_bus_valid;
    assign timeout_err = r_timeout_err;

    Mux4 #(.WIDTH(WIDTH)) u_mux (
        .i_sel (r_sel),
        .i_d0  (in0),
        .i_d1  (in1),
        .i_d2  (in2),
        .i_d3  (in3),
        .o_y   (bus_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter4
//  Description : Directed self-checking bench for bus_arbiter4 (MAX_HOLD = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter4;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       req = 4'b0000;
    logic [WIDTH-1:0] in0 = 32'hAAAA_0000;
    logic [WIDTH-1:0] in1 = 32'h1111_1111;
    logic [WIDTH-1:0] in2 = 32'h2222_2222;
    logic [WIDTH-1:0] in3 = 32'h3333_3333;
    logic             bus_ready = 1'b0;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] bus_out;
    logic             bus_valid;
    logic             timeout_err;

    int checks = 0;
    int failures = 0;

    bus_arbiter4 #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .bus_ready   (bus_ready),
        .gnt         (gnt),
        .sel         (sel),
        .bus_out     (bus_out),
        .bus_valid   (bus_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || bus_valid !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: gnt=%b sel=%0d valid=%b terr=%b, want 0000/0/0/0", gnt, sel, bus_valid, timeout_err);
        end
        checks++;
        if (bus_out !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL reset_bus_out: got %h want aaaa0000", bus_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || bus_valid !== 1'b1 || bus_out !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL single_grant: gnt=%b sel=%0d valid=%b out=%h, want 0001/0/1/aaaa0000", gnt, sel, bus_valid, bus_out);
        end
        in1 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus_out !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL unselected_input: out=%h want aaaa0000", bus_out);
        end
        req = 4'b0000;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_release: gnt=%b valid=%b want 0000/0", gnt, bus_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // Serve requester 3 first so ptr returns to 0.
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || bus_out !== 32'h3333_3333) begin
            failures++;
            $display("FAIL rr_setup: gnt=%b sel=%0d out=%h want 1000/3/33333333", gnt, sel, bus_out);
        end
        req = 4'b0000;
        bus_ready = 1'b1;
        tick();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt !== exp_seq[i] || bus_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_seq[%0d]: gnt=%b valid=%b want %b/1", i, gnt, bus_valid, exp_seq[i]);
            end
        end
        req = 4'b0000;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle: gnt=%b valid=%b want 0000/0", gnt, bus_valid);
        end
    endtask

    task automatic test_priority_ptr();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            failures++;
            $display("FAIL ptr2_pick: gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
        bus_ready = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || bus_out !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ptr2_next: gnt=%b sel=%0d out=%h want 0010/1/deadbeef", gnt, sel, bus_out);
        end
        req = 4'b0000;
        tick();
        bus_ready = 1'b0;
    endtask

    task automatic test_timeout();
        req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle[%0d]: gnt=%b terr=%b want 0100/0", i, gnt, timeout_err);
            end
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_release: terr=%b gnt=%b want 1/0010", timeout_err, gnt);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_pulse_width: terr=%b gnt=%b want 0/0010", timeout_err, gnt);
        end
        req = 4'b0000;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
    endtask

    task automatic test_abort();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL abort_setup: gnt=%b want 0100", gnt);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || timeout_err !== 1'b0 || bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_next: gnt=%b terr=%b valid=%b want 0001/0/1", gnt, timeout_err, bus_valid);
        end
        req = 4'b0000;
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || bus_out !== 32'h3333_3333) begin
            failures++;
            $display("FAIL areset_setup: gnt=%b out=%h want 1000/33333333", gnt, bus_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0 || sel !== 2'd0 || bus_out !== 32'hAAAA_0000) begin
            failures++;
            $display("FAIL areset_async: gnt=%b valid=%b sel=%0d out=%h want 0000/0/0/aaaa0000", gnt, bus_valid, sel, bus_out);
        end
        #1 reset = 1'b0;
        // Requester 0 wins only if ptr was cleared back to 0.
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || bus_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_ptr: gnt=%b valid=%b want 0001/1", gnt, bus_valid);
        end
        bus_ready = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL areset_regrant: gnt=%b want 1000", gnt);
        end
        req = 4'b0000;
        tick();
        bus_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority_ptr();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
